axi_aw_boundary_split: RTL and testbench

//  Write-address sequencer that pairs with the W-channel boundary protector. Accepts a

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_burst_len_calc.sv | 36 +++
 rtl/axi_aw_boundary_split.sv | 128 ++++++++++++
 tb/tb_axi_aw_boundary_split.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ============================================================================
// Package : axi_pkg
// Purpose : Shared AXI constants and the write-address sequencer state
//           encoding used by axi_aw_boundary_split and its helpers.
// Contents: AXI_BURST_INCR, AXI_SIZE_4B, AXI_BOUNDARY_BEATS, ST_* states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  // AXI burst type / size encodings
  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B        = 3'b010;

  // Number of 4-byte beats in one 4KB page
  localparam int         AXI_BOUNDARY_BEATS = 1024;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/axi_burst_len_calc.sv
// ============================================================================
// Module  : axi_burst_len_calc
// Purpose : Combinational burst length selection: the smallest of the
//           remaining beats, the beats left before the next 4KB page and
//           MAX_BURST_LEN.
// Ports   : rem_beats_i [16:0] beats still to issue (1..65536)
//           addr_word_i [9:0]  word index inside the 4KB page (addr[11:2])
//           blen_o      [8:0]  selected burst length in beats (1..256)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_len_calc #(
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [16:0] rem_beats_i,
  input  logic [9:0]  addr_word_i,
  output logic [8:0]  blen_o
);
  import axi_pkg::*;

  localparam logic [8:0] c_max_len = 9'(MAX_BURST_LEN);

  logic [10:0] w_dist;      // beats to the 4KB page end, 1..1024
  logic [8:0]  w_min_page;  // min(distance, MAX_BURST_LEN)

  always_comb begin
    w_dist     = 11'(AXI_BOUNDARY_BEATS) - {1'b0, addr_word_i};
    // Once the distance is below the cap (<=256) its low 9 bits are exact.
    w_min_page = (w_dist < {2'b00, c_max_len}) ? w_dist[8:0] : c_max_len;
    blen_o     = (rem_beats_i < {8'd0, w_min_page}) ? rem_beats_i[8:0] : w_min_page;
  end

endmodule

`default_nettype wire

// File: rtl/axi_aw_boundary_split.sv
// ============================================================================
// Module  : axi_aw_boundary_split
// Purpose : Write-address sequencer. Splits one write request into AXI INCR
//           bursts that never cross a 4KB page nor exceed MAX_BURST_LEN
//           beats, and pushes (beats-1) of every burst into the burst-length
//           FIFO in the same cycle as its AW handshake.
// Ports   : clk, rst_n (synchronous, active low)
//           s_req_addr/len/valid/ready        request input
//           m_axi_aw{addr,len,size,burst,valid,ready}   AXI AW channel
//           burst_len_fifo_wen/din/full_n    burst-length FIFO write side
//           req_done                         1-cycle pulse per finished request
// Note    : register updates carry no simulation delay in this RTL.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_aw_boundary_split #(
  parameter int MAX_BURST_LEN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_req_addr,
  input  logic [15:0] s_req_len,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic        burst_len_fifo_wen,
  output logic [7:0]  burst_len_fifo_din,
  input  logic        burst_len_fifo_full_n,
  output logic        req_done
);
  import axi_pkg::*;

  logic [1:0]  state_q,    state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [16:0] rem_q,      rem_d;
  logic [8:0]  blen_q,     blen_d;
  logic [31:0] awaddr_q,   awaddr_d;
  logic [7:0]  awlen_q,    awlen_d;

  logic [8:0]  w_blen;
  logic        w_aw_hs;

  axi_burst_len_calc #(
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .rem_beats_i (rem_q),
    .addr_word_i (cur_addr_q[11:2]),
    .blen_o      (w_blen)
  );

  // Only this block writes the FIFO, so full_n cannot fall while awvalid is
  // high and gating awvalid with full_n never withdraws a pending request.
  assign m_axi_awvalid      = (state_q == ST_ISSUE) && burst_len_fifo_full_n;
  assign w_aw_hs            = m_axi_awvalid && m_axi_awready;
  assign burst_len_fifo_wen = w_aw_hs;
  assign burst_len_fifo_din = awlen_q;
  assign m_axi_awaddr       = awaddr_q;
  assign m_axi_awlen        = awlen_q;
  assign m_axi_awsize       = AXI_SIZE_4B;
  assign m_axi_awburst      = AXI_BURST_INCR;
  assign s_req_ready        = (state_q == ST_IDLE);
  assign req_done           = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    blen_d     = blen_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    case (state_q)
      ST_IDLE: begin
        if (s_req_valid) begin
          state_d    = ST_CALC;
          cur_addr_d = s_req_addr & 32'hFFFF_FFFC;
          rem_d      = {1'b0, s_req_len} + 17'd1;
        end
      end
      ST_CALC: begin
        blen_d   = w_blen;
        awaddr_d = cur_addr_q;
        // blen of 256 wraps to 255 in 8 bits, which is the wanted awlen
        awlen_d  = w_blen[7:0] - 8'd1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_aw_hs) begin
          cur_addr_d = cur_addr_q + {21'd0, blen_q, 2'b00};
          rem_d      = rem_q - {8'd0, blen_q};
          state_d    = (rem_q == {8'd0, blen_q}) ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= 32'd0;
      rem_q      <= 17'd0;
      blen_q     <= 9'd0;
      awaddr_q   <= 32'd0;
      awlen_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      blen_q     <= blen_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_aw_boundary_split.sv
// ============================================================================
// Module  : tb_axi_aw_boundary_split
// Purpose : Self-checking bench for axi_aw_boundary_split with a scoreboard
//           of expected AW bursts and a page-splitting reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_aw_boundary_split;

  localparam int MAX_LEN = 256;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_req_addr;
  logic [15:0] s_req_len;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic        burst_len_fifo_wen;
  logic [7:0]  burst_len_fifo_din;
  logic        burst_len_fifo_full_n;
  logic        req_done;

  axi_aw_boundary_split #(.MAX_BURST_LEN(MAX_LEN)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .s_req_addr            (s_req_addr),
    .s_req_len             (s_req_len),
    .s_req_valid           (s_req_valid),
    .s_req_ready           (s_req_ready),
    .m_axi_awaddr          (m_axi_awaddr),
    .m_axi_awlen           (m_axi_awlen),
    .m_axi_awsize          (m_axi_awsize),
    .m_axi_awburst         (m_axi_awburst),
    .m_axi_awvalid         (m_axi_awvalid),
    .m_axi_awready         (m_axi_awready),
    .burst_len_fifo_wen    (burst_len_fifo_wen),
    .burst_len_fifo_din    (burst_len_fifo_din),
    .burst_len_fifo_full_n (burst_len_fifo_full_n),
    .req_done              (req_done)
  );

  always #5 clk = ~clk;

  aw_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_seen = 0;
  int  hs_cnt    = 0;
  bit  rand_en   = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: walk the request one burst at a time using page arithmetic.
  task automatic model_push(input logic [31:0] addr, input logic [15:0] len);
    logic [31:0] a;
    int          rem, room, b;
    a   = {addr[31:2], 2'b00};
    rem = int'(len) + 1;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = rem;
      if (room < b)    b = room;
      if (MAX_LEN < b) b = MAX_LEN;
      exp_q.push_back('{addr: a, len: 8'(b - 1)});
      a   = a + 32'(4 * b);
      rem = rem - b;
    end
  endtask

  // Monitor: every AW handshake must coincide with a FIFO write carrying awlen.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("hold_awaddr", m_axi_awaddr, prev_addr);
        chk("hold_awlen", 32'(m_axi_awlen), 32'(prev_len));
      end
      if (m_axi_awvalid && m_axi_awready) begin
        hs_cnt++;
        chk("hs_wen", 32'(burst_len_fifo_wen), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_aw", m_axi_awaddr, 32'hDEAD_BEEF);
        end else begin
          aw_t e;
          e = exp_q.pop_front();
          chk("awaddr", m_axi_awaddr, e.addr);
          chk("awlen", 32'(m_axi_awlen), 32'(e.len));
          chk("fifo_din", 32'(burst_len_fifo_din), 32'(e.len));
          chk("awsize", 32'(m_axi_awsize), 32'd2);
          chk("awburst", 32'(m_axi_awburst), 32'd1);
        end
      end else if (burst_len_fifo_wen) begin
        chk("stray_wen", 32'(burst_len_fifo_wen), 32'd0);
      end
      if (req_done) begin
        done_seen++;
        chk("done_ready_low", 32'(s_req_ready), 32'd0);
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
      end
      prev_hold = m_axi_awvalid && !m_axi_awready;
      prev_addr = m_axi_awaddr;
      prev_len  = m_axi_awlen;
    end
  end

  // Random back-pressure; full_n never falls while awvalid is high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) begin
        burst_len_fifo_full_n = m_axi_awvalid ? 1'b1 : ($urandom_range(0, 3) != 0);
        m_axi_awready         = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic send_req(input logic [31:0] addr, input logic [15:0] len);
    int n = 0;
    while (!s_req_ready && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_timeout", 32'(s_req_ready), 32'd1);
    s_req_addr  = addr;
    s_req_len   = len;
    s_req_valid = 1'b1;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("req_done_count", 32'(done_seen), 32'(target));
  endtask

  initial begin
    int tgt, wen_base, hs_base, n;
    logic [31:0] ra;
    logic [15:0] rl;
    rst_n = 1'b0; s_req_valid = 1'b0; s_req_addr = '0; s_req_len = '0;
    m_axi_awready = 1'b1; burst_len_fifo_full_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_req_ready), 32'd1);
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_wen", 32'(burst_len_fifo_wen), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    chk("rst_awlen", 32'(m_axi_awlen), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single burst
    tgt = done_seen + 1;
    exp_q.push_back('{addr: 32'h0, len: 8'd15});
    send_req(32'h0, 16'd15);
    // first awvalid two cycles after acceptance
    @(negedge clk);
    chk("latency_calc_awvalid", 32'(m_axi_awvalid), 32'd0);
    @(negedge clk);
    chk("latency_issue_awvalid", 32'(m_axi_awvalid), 32'd1);
    wait_done(tgt);

    // 2: 4KB crossing
    tgt = done_seen + 1;
    exp_q.push_back('{addr: 32'h0FF0, len: 8'd3});
    exp_q.push_back('{addr: 32'h1000, len: 8'd11});
    send_req(32'h0FF0, 16'd15);
    wait_done(tgt);

    // 3: MAX_BURST_LEN splitting
    tgt = done_seen + 1; hs_base = hs_cnt;
    exp_q.push_back('{addr: 32'h000, len: 8'd255});
    exp_q.push_back('{addr: 32'h400, len: 8'd255});
    exp_q.push_back('{addr: 32'h800, len: 8'd87});
    send_req(32'h0, 16'd599);
    wait_done(tgt);
    chk("t3_fifo_writes", 32'(hs_cnt - hs_base), 32'd3);

    // 4: single beat right before the page end, ignored low address bits
    tgt = done_seen + 1;
    exp_q.push_back('{addr: 32'h0FFC, len: 8'd0});
    send_req(32'h0FFF, 16'd0);
    wait_done(tgt);
    @(negedge clk);
    chk("t4_ready_after_done", 32'(s_req_ready), 32'd1);

    // 5: FIFO full then awready low
    tgt = done_seen + 1; wen_base = hs_cnt;
    burst_len_fifo_full_n = 1'b0; m_axi_awready = 1'b1;
    exp_q.push_back('{addr: 32'h2000, len: 8'd7});
    send_req(32'h2000, 16'd7);
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_full_awvalid", 32'(m_axi_awvalid), 32'd0);
      chk("t5_full_wen", 32'(burst_len_fifo_wen), 32'd0);
    end
    @(posedge clk); #1;
    burst_len_fifo_full_n = 1'b1; m_axi_awready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t5_stall_awvalid", 32'(m_axi_awvalid), 32'd1);
      chk("t5_stall_awaddr", m_axi_awaddr, 32'h2000);
      chk("t5_stall_awlen", 32'(m_axi_awlen), 32'd7);
      chk("t5_stall_wen", 32'(burst_len_fifo_wen), 32'd0);
    end
    @(posedge clk); #1;
    m_axi_awready = 1'b1;
    wait_done(tgt);
    chk("t5_one_wen", 32'(hs_cnt - wen_base), 32'd1);

    // 6: reset during the second burst
    hs_base = hs_cnt;
    exp_q.push_back('{addr: 32'h000, len: 8'd255});
    exp_q.push_back('{addr: 32'h400, len: 8'd255});
    exp_q.push_back('{addr: 32'h800, len: 8'd87});
    send_req(32'h0, 16'd599);
    n = 0;
    while (hs_cnt == hs_base && n < 100) begin @(posedge clk); #1; n++; end
    m_axi_awready = 1'b0;
    n = 0;
    while (!m_axi_awvalid && n < 100) begin @(negedge clk); n++; end
    chk("t6_second_burst", 32'(m_axi_awvalid), 32'd1);
    tgt = done_seen;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("t6_wen", 32'(burst_len_fifo_wen), 32'd0);
    chk("t6_ready", 32'(s_req_ready), 32'd1);
    chk("t6_done", 32'(req_done), 32'd0);
    exp_q.delete();
    rst_n = 1'b1; m_axi_awready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_done", 32'(done_seen), 32'(tgt));
    chk("t6_no_aw", 32'(m_axi_awvalid), 32'd0);

    // Random requests against the reference model
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = {$urandom_range(0, 32'hFFFFF), 12'h000} - 32'($urandom_range(0, 64));
        2:       ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 2048));
        default: ra = 32'($urandom_range(0, 16'hFFFF));
      endcase
      rl = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3000))
                                       : 16'($urandom_range(0, 300));
      tgt = done_seen + 1;
      model_push(ra, rl);
      send_req(ra, rl);
      wait_done(tgt);
    end
    rand_en = 1'b0;
    repeat (3) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
